input_vc_buffer: RTL and testbench
==================================

# input_vc_buffer

Per-input-port virtual-channel buffer of the router. Accepts flits arriving on one input link, stores them in one FIFO per VC, and presents every VC's head flit and look-ahead route to the allocation and switch-traversal stages, which consume them through the switch's data-head inputs. Pops the addressed VC on the switch-traversal read strobe and returns one credit per popped flit to the upstream router.

## Interface
- VC_NUM, 4, number of VCs on this input port (1..6)
- VC_DEPTH, 4, flit entries per VC (power of two, ≥2)
- FLIT_W, 256, flit payload width
- VC_ID_W, 3, width of VC id fields (codebase-wide VC_ID_NUM_MAX_W)
- LAR_W, 3, look-ahead routing field width
- VC_IDX_W, (VC_NUM>1 ? $clog2(VC_NUM) : 1), derived; do not override

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx_flit_v_i  input  1  incoming flit valid
- rx_flit_i  input  FLIT_W  incoming flit payload
- rx_flit_vc_id_i  input  VC_ID_W  target VC of incoming flit
- rx_flit_look_ahead_routing_i  input  LAR_W  look-ahead route of incoming flit
- inport_read_enable_st_stage_i  input  1  switch-traversal pop strobe
- inport_read_vc_id_st_stage_i  input  VC_ID_W  VC to pop
- vc_data_head_o  output  VC_NUM*FLIT_W  head payload per VC, VC k at [k*FLIT_W +: FLIT_W]
- vc_head_vld_o  output  VC_NUM  VC k non-empty
- vc_look_ahead_routing_head_o  output  VC_NUM*LAR_W  head look-ahead route per VC
- tx_lcrd_v_o  output  1  credit return valid to upstream
- tx_lcrd_id_o  output  VC_ID_W  VC of returned credit
- err_o  output  3  sticky flags: [0] overflow, [1] underflow, [2] illegal VC id

## Operation
- Storage: per VC, VC_DEPTH entries of {look-ahead, payload}; read pointer, write pointer (VC_IDX of $clog2(VC_DEPTH) bits, wrap naturally), occupancy counter of $clog2(VC_DEPTH)+1 bits.
- Push: rx_flit_v_i=1 and rx_flit_vc_id_i<VC_NUM → entry written at wr_ptr, wr_ptr+1, count+1.
- Pop: inport_read_enable_st_stage_i=1 and id<VC_NUM and VC non-empty → rd_ptr+1, count−1.
- Simultaneous push and pop, same VC: both performed, count unchanged; legal even when full (pop frees slot in same edge) and when count=1.
- Simultaneous push and pop, different VCs: independent.
- Push to full VC without same-VC pop: flit dropped, state unchanged, err_o[0] set.
- Pop of empty VC: ignored, no credit, err_o[1] set. Push to empty VC with same-VC pop in same cycle counts as pop of empty: pop ignored, push performed.
- Any VC id ≥VC_NUM on a valid push or pop: operation dropped, err_o[2] set.
- Head outputs are combinational reads of storage at rd_ptr; payload of empty VC is don't-care, vc_head_vld_o=0.
- Credit: each performed pop produces tx_lcrd_v_o=1 with tx_lcrd_id_o=popped VC in the following cycle; otherwise tx_lcrd_v_o=0, id holds last value.
- err_o bits are sticky until reset.

## Timing
- Reset (async assert, release synchronous to clk by upstream reset logic): all pointers and counts 0, vc_head_vld_o=0, tx_lcrd_v_o=0, tx_lcrd_id_o=0, err_o=0. Storage not reset. Reset mid-operation discards all buffered flits; no credits are returned for them.
- Push at edge N → vc_head_vld_o and head data visible after edge N (latency 1, no bypass).
- Pop at edge N → next entry (or vld=0) visible after edge N; credit valid for cycle after edge N, exactly one cycle.
- Max throughput: one push and one pop per cycle.

## Configuration
- INPUT_VC_BUFFER_ERR_CHECK_EN defined: err_o detection logic as above.
- Not defined: err_o tied to 3'b000; dropping of overflow/underflow/illegal-id operations still performed.

## Test plan
- Reset, push flit 0xA5 (LAR 3) to VC 2 → next cycle vc_head_vld_o=4'b0100, VC2 head 0xA5, LAR 3; other vld 0.
- Push 4 flits 1,2,3,4 into VC 1, pop 4 times → heads 1,2,3,4 in order, four credits id 1 on consecutive cycles, vld[1]=0 at end; pointers wrapped correctly on second round of 4.
- Fill VC 0 (4 flits), same-cycle push 9 and pop → count stays 4, credit id 0, head becomes flit 2, flit 9 read out last; err_o=0.
- Fifth push to full VC 3 without pop → dropped, err_o[0]=1; pop empty VC 1 → no credit, err_o[1]=1; push with vc id 5 (VC_NUM=4) → err_o[2]=1.
- Push to VC 0 and pop VC 1 same cycle, then assert rst_n=0 mid-stream → all vld 0, tx_lcrd_v_o=0, err_o=0 immediately (asynchronous).
- Build without INPUT_VC_BUFFER_ERR_CHECK_EN, repeat overflow case → err_o stays 0, FIFO contents unchanged.

Source files
------------

// File: rtl/input_vc_buffer.sv
// Per-input-port VC buffer: one FIFO per VC, head flit + look-ahead route exposed per VC, one credit per pop.
// Latency: push visible at head one cycle after the push edge; credit valid the cycle after the pop edge.
// Backpressure: none on the link; upstream is credit-limited, so overflow/underflow/bad-id ops are dropped.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rx_flit_*                      incoming flit (valid, payload, target VC, look-ahead route)
//   inport_read_*_st_stage_i       switch-traversal pop strobe and VC id
//   vc_data_head_o / vc_head_vld_o / vc_look_ahead_routing_head_o   per-VC head view
//   tx_lcrd_v_o / tx_lcrd_id_o     credit return to upstream
//   err_o                          sticky {illegal id, underflow, overflow}; live only when
//                                  INPUT_VC_BUFFER_ERR_CHECK_EN is defined, otherwise tied to zero

// Generic FIFO: head is a combinational read at rd_ptr, push/pop must be pre-qualified by the caller.
// Latency: written entry visible at head one cycle after the push edge.
// Backpressure: none; caller never pushes when full without a same-cycle pop, nor pops when empty.
module fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_en,
    input  logic         pop_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            if (push_en && !pop_en)      count <= count + 1'b1;
            else if (!push_en && pop_en) count <= count - 1'b1;
        end
    end

    // Storage is deliberately not reset; only valid entries are ever observed.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

module input_vc_buffer #(
    parameter int VC_NUM   = 4,
    parameter int VC_DEPTH = 4,
    parameter int FLIT_W   = 256,
    parameter int VC_ID_W  = 3,
    parameter int LAR_W    = 3,
    parameter int VC_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_flit_v_i,
    input  logic [FLIT_W-1:0]          rx_flit_i,
    input  logic [VC_ID_W-1:0]         rx_flit_vc_id_i,
    input  logic [LAR_W-1:0]           rx_flit_look_ahead_routing_i,
    input  logic                       inport_read_enable_st_stage_i,
    input  logic [VC_ID_W-1:0]         inport_read_vc_id_st_stage_i,
    output logic [VC_NUM*FLIT_W-1:0]   vc_data_head_o,
    output logic [VC_NUM-1:0]          vc_head_vld_o,
    output logic [VC_NUM*LAR_W-1:0]    vc_look_ahead_routing_head_o,
    output logic                       tx_lcrd_v_o,
    output logic [VC_ID_W-1:0]         tx_lcrd_id_o,
    output logic [2:0]                 err_o
);
    localparam int ENT_W = LAR_W + FLIT_W;
    localparam logic [VC_ID_W-1:0] VC_NUM_ID = VC_ID_W'(VC_NUM);

    logic                rx_id_ok;
    logic                rd_id_ok;
    logic [VC_NUM-1:0]   hit_push;
    logic [VC_NUM-1:0]   hit_pop;
    logic [VC_NUM-1:0]   push_do;
    logic [VC_NUM-1:0]   pop_do;
    logic [VC_NUM-1:0]   empty;
    logic [VC_NUM-1:0]   full;
    logic [ENT_W-1:0]    head_ent [VC_NUM];
    logic [VC_IDX_W-1:0] pop_idx;

    assign rx_id_ok = (rx_flit_vc_id_i < VC_NUM_ID);
    assign rd_id_ok = (inport_read_vc_id_st_stage_i < VC_NUM_ID);

    genvar k;
    generate
        for (k = 0; k < VC_NUM; k++) begin : g_vc
            assign hit_push[k] = rx_flit_v_i && rx_id_ok && (rx_flit_vc_id_i == VC_ID_W'(k));
            assign hit_pop[k]  = inport_read_enable_st_stage_i && rd_id_ok &&
                                 (inport_read_vc_id_st_stage_i == VC_ID_W'(k));
            // A pop on an empty VC is ignored even if a push lands in the same cycle.
            assign pop_do[k]   = hit_pop[k] && !empty[k];
            // A full VC still accepts a push when the same edge pops it.
            assign push_do[k]  = hit_push[k] && (!full[k] || pop_do[k]);

            fifo #(
                .DEPTH (VC_DEPTH),
                .W     (ENT_W)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push_en (push_do[k]),
                .pop_en  (pop_do[k]),
                .din     ({rx_flit_look_ahead_routing_i, rx_flit_i}),
                .head    (head_ent[k]),
                .empty   (empty[k]),
                .full    (full[k])
            );

            assign vc_data_head_o[k*FLIT_W +: FLIT_W]              = head_ent[k][FLIT_W-1:0];
            assign vc_look_ahead_routing_head_o[k*LAR_W +: LAR_W]  = head_ent[k][ENT_W-1:FLIT_W];
            assign vc_head_vld_o[k]                                = !empty[k];
        end
    endgenerate

    // Only a legal id can produce a pop, so the low bits carry the full VC index.
    assign pop_idx = inport_read_vc_id_st_stage_i[VC_IDX_W-1:0];

    // Credit id holds its last value while no credit is being returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_lcrd_v_o  <= 1'b0;
            tx_lcrd_id_o <= '0;
        end else begin
            tx_lcrd_v_o <= |pop_do;
            if (|pop_do) tx_lcrd_id_o <= VC_ID_W'(pop_idx);
        end
    end

`ifdef INPUT_VC_BUFFER_ERR_CHECK_EN
    logic       overflow;
    logic       underflow;
    logic       illegal_id;
    logic [2:0] err_q;

    assign overflow   = |(hit_push & full & ~pop_do);
    assign underflow  = |(hit_pop & empty);
    assign illegal_id = (rx_flit_v_i && !rx_id_ok) ||
                        (inport_read_enable_st_stage_i && !rd_id_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 3'b000;
        else        err_q <= err_q | {illegal_id, underflow, overflow};
    end

    assign err_o = err_q;
`else
    assign err_o = 3'b000;
`endif
endmodule

// File: tb/tb_input_vc_buffer.sv
// Self-checking bench for input_vc_buffer with a queue-based reference model.
// Latency: model state advances at each rising edge; outputs compared every falling edge.
// Backpressure: n/a (bench drives push/pop freely, including illegal ones).
module tb_input_vc_buffer;
    localparam int VCN = 4;
    localparam int DEP = 4;
    localparam int FW  = 256;
    localparam int IDW = 3;
    localparam int LW  = 3;

    logic              clk;
    logic              rst_n;
    logic              rx_flit_v_i;
    logic [FW-1:0]     rx_flit_i;
    logic [IDW-1:0]    rx_flit_vc_id_i;
    logic [LW-1:0]     rx_flit_look_ahead_routing_i;
    logic              inport_read_enable_st_stage_i;
    logic [IDW-1:0]    inport_read_vc_id_st_stage_i;
    logic [VCN*FW-1:0] vc_data_head_o;
    logic [VCN-1:0]    vc_head_vld_o;
    logic [VCN*LW-1:0] vc_look_ahead_routing_head_o;
    logic              tx_lcrd_v_o;
    logic [IDW-1:0]    tx_lcrd_id_o;
    logic [2:0]        err_o;

    input_vc_buffer dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .rx_flit_v_i                   (rx_flit_v_i),
        .rx_flit_i                     (rx_flit_i),
        .rx_flit_vc_id_i               (rx_flit_vc_id_i),
        .rx_flit_look_ahead_routing_i  (rx_flit_look_ahead_routing_i),
        .inport_read_enable_st_stage_i (inport_read_enable_st_stage_i),
        .inport_read_vc_id_st_stage_i  (inport_read_vc_id_st_stage_i),
        .vc_data_head_o                (vc_data_head_o),
        .vc_head_vld_o                 (vc_head_vld_o),
        .vc_look_ahead_routing_head_o  (vc_look_ahead_routing_head_o),
        .tx_lcrd_v_o                   (tx_lcrd_v_o),
        .tx_lcrd_id_o                  (tx_lcrd_id_o),
        .err_o                         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [FW-1:0] d;
        logic [LW-1:0] l;
    } ent_t;

    ent_t       mq [VCN][$];
    logic       m_cv;
    logic [2:0] m_cid;
    logic [2:0] m_err;

`ifdef INPUT_VC_BUFFER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic check(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < VCN; k++) mq[k].delete();
        m_cv  = 1'b0;
        m_cid = '0;
        m_err = '0;
    endtask

    // Reference behaviour: queues per VC, pop judged on pre-edge occupancy, push judged after the pop.
    task automatic model_update(input bit pv, input logic [2:0] pid, input logic [FW-1:0] pd,
                                input logic [2:0] pl, input bit rv, input logic [2:0] rid);
        bit   p_ok, r_ok, popd, pushd;
        ent_t e;
        p_ok  = pv && (int'(pid) < VCN);
        r_ok  = rv && (int'(rid) < VCN);
        popd  = r_ok && (mq[rid].size() > 0);
        if (popd) void'(mq[rid].pop_front());
        pushd = p_ok && (mq[pid].size() < DEP);
        if (pushd) begin
            e.d = pd;
            e.l = pl;
            mq[pid].push_back(e);
        end
        if (p_ok && !pushd) m_err[0] = 1'b1;
        if (r_ok && !popd)  m_err[1] = 1'b1;
        if ((pv && int'(pid) >= VCN) || (rv && int'(rid) >= VCN)) m_err[2] = 1'b1;
        m_cv = popd;
        if (popd) m_cid = rid;
    endtask

    task automatic step(input bit pv, input logic [2:0] pid, input logic [FW-1:0] pd,
                        input logic [2:0] pl, input bit rv, input logic [2:0] rid);
        rx_flit_v_i                   = pv;
        rx_flit_vc_id_i               = pid;
        rx_flit_i                     = pd;
        rx_flit_look_ahead_routing_i  = pl;
        inport_read_enable_st_stage_i = rv;
        inport_read_vc_id_st_stage_i  = rid;
        @(posedge clk);
        model_update(pv, pid, pd, pl, rv, rid);
        #1;
    endtask

    task automatic idle_inputs();
        rx_flit_v_i                   = 1'b0;
        rx_flit_vc_id_i               = '0;
        rx_flit_i                     = '0;
        rx_flit_look_ahead_routing_i  = '0;
        inport_read_enable_st_stage_i = 1'b0;
        inport_read_vc_id_st_stage_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < VCN; k++) begin
                check($sformatf("vld%0d", k), vc_head_vld_o[k], mq[k].size() > 0);
                if (mq[k].size() > 0) begin
                    check($sformatf("head%0d", k), vc_data_head_o[k*FW +: FW], mq[k][0].d);
                    check($sformatf("lar%0d", k), vc_look_ahead_routing_head_o[k*LW +: LW], mq[k][0].l);
                end
            end
            check("crd_v", tx_lcrd_v_o, m_cv);
            check("crd_id", tx_lcrd_id_o, m_cid);
            check("err", err_o, ERR_EN ? m_err : 3'b000);
        end
    end

    function automatic logic [FW-1:0] rnd_flit();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check("rst_vld", vc_head_vld_o, 4'b0000);
        check("rst_crd", tx_lcrd_v_o, 1'b0);
        check("rst_err", err_o, 3'b000);
        do_reset();

        // Single push to VC 2.
        step(1, 3'd2, 256'hA5, 3'd3, 0, 3'd0);
        check("t1_vld", vc_head_vld_o, 4'b0100);
        check("t1_head", vc_data_head_o[2*FW +: FW], 256'hA5);
        check("t1_lar", vc_look_ahead_routing_head_o[2*LW +: LW], 3'd3);
        step(0, 3'd0, '0, 3'd0, 0, 3'd0);
        check("t1_nocrd", tx_lcrd_v_o, 1'b0);

        // Two rounds of fill/drain on VC 1 to exercise pointer wrap.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 4; i++) step(1, 3'd1, FW'(i + 16 * r), 3'(i), 0, 3'd0);
            for (int i = 1; i <= 4; i++) begin
                check("t2_head", vc_data_head_o[1*FW +: FW], FW'(i + 16 * r));
                step(0, 3'd0, '0, 3'd0, 1, 3'd1);
                check("t2_crd_v", tx_lcrd_v_o, 1'b1);
                check("t2_crd_id", tx_lcrd_id_o, 3'd1);
            end
            check("t2_empty", vc_head_vld_o[1], 1'b0);
        end

        // Full VC 0 with same-cycle push and pop.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 3'd0, FW'(i), 3'd0, 0, 3'd0);
        step(1, 3'd0, 256'h9, 3'd1, 1, 3'd0);
        check("t3_head", vc_data_head_o[0 +: FW], 256'h2);
        check("t3_crd_v", tx_lcrd_v_o, 1'b1);
        check("t3_crd_id", tx_lcrd_id_o, 3'd0);
        check("t3_err", err_o, 3'b000);
        for (int i = 3; i <= 5; i++) step(0, 3'd0, '0, 3'd0, 1, 3'd0);
        check("t3_last", vc_data_head_o[0 +: FW], 256'h9);
        check("t3_last_lar", vc_look_ahead_routing_head_o[0 +: LW], 3'd1);
        step(0, 3'd0, '0, 3'd0, 1, 3'd0);
        check("t3_drained", vc_head_vld_o, 4'b0000);

        // Error cases: overflow, underflow, illegal id.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 3'd3, FW'(48 + i), 3'd2, 0, 3'd0);
        step(1, 3'd3, 256'h99, 3'd2, 0, 3'd0);
        check("t4_ovf", err_o, ERR_EN ? 3'b001 : 3'b000);
        check("t4_head", vc_data_head_o[3*FW +: FW], 256'd49);
        check("t4_vld", vc_head_vld_o, 4'b1000);
        step(0, 3'd0, '0, 3'd0, 1, 3'd1);
        check("t4_udf_crd", tx_lcrd_v_o, 1'b0);
        check("t4_udf", err_o, ERR_EN ? 3'b011 : 3'b000);
        step(1, 3'd5, 256'h77, 3'd0, 0, 3'd0);
        check("t4_ill", err_o, ERR_EN ? 3'b111 : 3'b000);
        check("t4_ill_vld", vc_head_vld_o, 4'b1000);
        for (int i = 1; i <= 4; i++) step(0, 3'd0, '0, 3'd0, 1, 3'd3);
        check("t4_drain", vc_head_vld_o, 4'b0000);

        // Asynchronous reset mid-stream.
        do_reset();
        step(1, 3'd1, 256'h11, 3'd1, 0, 3'd0);
        step(1, 3'd0, 256'h22, 3'd2, 1, 3'd1);
        check("t5_pre_crd", tx_lcrd_v_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_vld", vc_head_vld_o, 4'b0000);
        check("t5_crd", tx_lcrd_v_o, 1'b0);
        check("t5_err", err_o, 3'b000);
        do_reset();

        // Randomized traffic with occasional illegal ids and one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            bit         pv, rv;
            logic [2:0] pid, rid;
            if (c == 1500) do_reset();
            pv  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 2) != 0);
            pid = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            rid = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            step(pv, pid, rnd_flit(), 3'($urandom_range(0, 7)), rv, rid);
        end

        idle_inputs();
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
